// File: rtl/ucaspian_synapse.sv
// uCaspian synapse stage: walks a synapse range held in a 4096x16 RAM and emits {target, weight} events to the dendrite.
// Optional build macro UCASPIAN_SYN_SKIP_ZERO_EN suppresses zero-weight synapses instead of emitting them.
module ucaspian_synapse (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        clear_act,
  input  logic        clear_config,
  output logic        clear_done,
  input  logic [11:0] config_addr,
  input  logic [11:0] config_value,
  input  logic [2:0]  config_byte,
  input  logic        config_enable,
  input  logic [11:0] syn_start,
  input  logic [11:0] syn_end,
  input  logic        syn_vld,
  output logic        syn_rdy,
  output logic [7:0]  dend_addr,
  output logic [7:0]  dend_charge,
  output logic        dend_vld,
  input  logic        dend_rdy,
  output logic        step_done
);

  typedef enum logic [1:0] {IDLE, READ, OUTPUT} state_t;

  state_t      r_state;
  logic [15:0] r_mem [4096];
  logic [7:0]  r_weight;
  logic [11:0] r_cur;
  logic [11:0] r_end;
  logic [11:0] r_clrAddr;
  logic        r_cfgClrDone;
  logic        r_synRdy;
  logic        r_dendVld;
  logic [7:0]  r_dendAddr;
  logic [7:0]  r_dendCharge;
  logic        r_stepDone;
  logic        r_clearDone;

  logic [15:0] w_rdWord;
  logic        w_emit;
  logic        w_advance;
  logic        w_clrWrite;
  logic        w_cfgWrite;
  logic        w_unused;

  assign w_rdWord   = r_mem[r_cur];
  assign w_clrWrite = !reset && enable && clear_config && !r_cfgClrDone;
  assign w_cfgWrite = config_enable && !clear_config && (config_byte == 3'd3);
  assign w_unused   = &{1'b0, config_value[11:8]};

  // A synapse with a zero weight can be dropped here so it never reaches the dendrite.
`ifdef UCASPIAN_SYN_SKIP_ZERO_EN
  assign w_emit = (w_rdWord[15:8] != 8'd0);
`else
  assign w_emit = 1'b1;
`endif

  // A suppressed word (dend_vld low in OUTPUT) advances as if it had been accepted.
  assign w_advance = !r_dendVld || dend_rdy;

  assign syn_rdy     = r_synRdy;
  assign dend_vld    = r_dendVld;
  assign dend_addr   = r_dendAddr;
  assign dend_charge = r_dendCharge;
  assign step_done   = r_stepDone;
  assign clear_done  = r_clearDone;

  always_ff @(posedge clk) begin
    if (w_clrWrite) begin
      r_mem[r_clrAddr] <= 16'd0;
    end else if (w_cfgWrite) begin
      r_mem[config_addr] <= {r_weight, config_value[7:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_weight <= 8'd0;
    end else if (config_enable && !clear_config && (config_byte == 3'd2)) begin
      r_weight <= config_value[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_synRdy     <= 1'b0;
      r_dendVld    <= 1'b0;
      r_dendAddr   <= 8'd0;
      r_dendCharge <= 8'd0;
      r_stepDone   <= 1'b0;
      r_clearDone  <= 1'b0;
      r_cur        <= 12'd0;
      r_end        <= 12'd0;
      r_clrAddr    <= 12'd0;
      r_cfgClrDone <= 1'b0;
    end else if (enable) begin
      if (clear_config) begin
        r_state    <= IDLE;
        r_synRdy   <= 1'b0;
        r_dendVld  <= 1'b0;
        r_stepDone <= 1'b0;
        // clear_done follows the RAM sweep only, even if clear_act raised it earlier.
        if (!r_cfgClrDone) begin
          r_clrAddr    <= r_clrAddr + 12'd1;
          r_cfgClrDone <= (r_clrAddr == 12'hFFF);
          r_clearDone  <= (r_clrAddr == 12'hFFF);
        end else begin
          r_clearDone <= 1'b1;
        end
      end else if (clear_act) begin
        r_state      <= IDLE;
        r_synRdy     <= 1'b0;
        r_dendVld    <= 1'b0;
        r_stepDone   <= 1'b0;
        r_clearDone  <= 1'b1;
        r_clrAddr    <= 12'd0;
        r_cfgClrDone <= 1'b0;
      end else begin
        r_clearDone  <= 1'b0;
        r_clrAddr    <= 12'd0;
        r_cfgClrDone <= 1'b0;
        case (r_state)
          IDLE: begin
            r_synRdy <= 1'b1;
            if (r_synRdy && syn_vld) begin
              r_stepDone <= 1'b0;
              if (syn_end >= syn_start) begin
                r_cur    <= syn_start;
                r_end    <= syn_end;
                r_synRdy <= 1'b0;
                r_state  <= READ;
              end
            end else begin
              r_stepDone <= 1'b1;
            end
          end
          READ: begin
            r_dendAddr   <= w_rdWord[7:0];
            r_dendCharge <= w_rdWord[15:8];
            r_dendVld    <= w_emit;
            r_state      <= OUTPUT;
          end
          OUTPUT: begin
            if (w_advance) begin
              r_dendVld <= 1'b0;
              if (r_cur == r_end) begin
                r_state <= IDLE;
              end else begin
                r_cur   <= r_cur + 12'd1;
                r_state <= READ;
              end
            end
          end
          default: begin
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
